// File: rtl/ac97_sdata_in_rx_pkg.sv
// ac97_sdata_in_rx_pkg
// Shared definitions for the AC'97 SDATA_IN receiver: frame length, bit
// index width, slot boundary indices (frame bit 255 is the first bit after
// the sync rising edge), tag bit positions, receiver state encoding and
// small helpers for locating fields inside the frame.
package ac97_sdata_in_rx_pkg;

   localparam int FRAME_LEN = 256;
   localparam int IDX_W     = $clog2(FRAME_LEN);

   // Most significant bit index of each slot; each slot is 20 bits wide
   // except the 16-bit tag.
   localparam logic [IDX_W-1:0] TAG_HI   = 8'd255;
   localparam logic [IDX_W-1:0] SLOT1_HI = 8'd239;
   localparam logic [IDX_W-1:0] SLOT2_HI = 8'd219;
   localparam logic [IDX_W-1:0] SLOT3_HI = 8'd199;
   localparam logic [IDX_W-1:0] SLOT4_HI = 8'd179;
   // Last bit of slot 4; the frame commits on the edge after this bit.
   localparam logic [IDX_W-1:0] SLOT4_LO = 8'd160;

   // Tag bit positions (bit 15 is the first tag bit on the wire).
   localparam int TAG_READY = 15;
   localparam int TAG_SLOT1 = 14;
   localparam int TAG_SLOT2 = 13;
   localparam int TAG_SLOT3 = 12;
   localparam int TAG_SLOT4 = 11;

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } rx_state_e;

   // Frame bit index carrying bit 'bit_no' of the tag.
   function automatic logic [IDX_W-1:0] tag_pos(input int bit_no);
      return TAG_HI - IDX_W'(15 - bit_no);
   endfunction

   // Frame bit index carrying bit 'bit_no' of the slot whose MSB sits at 'slot_hi'.
   function automatic logic [IDX_W-1:0] slot_pos(input logic [IDX_W-1:0] slot_hi,
                                                 input int bit_no);
      return slot_hi - IDX_W'(19 - bit_no);
   endfunction

   // True when lo <= idx <= hi; written as a modular window so that a
   // window touching index 255 needs no always-true comparison.
   function automatic logic in_range(input logic [IDX_W-1:0] idx,
                                     input logic [IDX_W-1:0] hi,
                                     input logic [IDX_W-1:0] lo);
      return IDX_W'(hi - idx) <= IDX_W'(hi - lo);
   endfunction

endpackage

// File: rtl/ac97_frame_counter.sv
// ac97_frame_counter
// Frame alignment for the AC'97 SDATA_IN receiver. Detects sync rising
// edges, tracks the bit index inside the 256-bit frame, holds the
// HUNT/LOCKED state and pulses frame_err on a misplaced or missing sync.
// All state changes on the falling edge of clk.
// Ports:
//   clk       in   codec bit clock (falling edge active)
//   rst       in   synchronous active-high reset
//   sync      in   frame sync
//   in_frame  out  the bit sampled on this edge belongs to a frame
//   cur_idx   out  frame bit index of the bit sampled on this edge
//   frame_err out  one-cycle framing error pulse
module ac97_frame_counter
   import ac97_sdata_in_rx_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             sync,
   output logic             in_frame,
   output logic [IDX_W-1:0] cur_idx,
   output logic             frame_err
);

   logic             sync_prev_r;
   rx_state_e        state_r;
   logic [IDX_W-1:0] bit_idx_r;   // index expected for the next sample
   logic             rise_s;

   // Sync edge detect and index of the bit being sampled on this edge.
   always_comb begin
      rise_s   = sync & ~sync_prev_r;
      in_frame = 1'b0;
      cur_idx  = 8'd0;
      if (rise_s) begin
         // Any sync rising edge starts a frame at bit 255, expected or not.
         in_frame = 1'b1;
         cur_idx  = TAG_HI;
      end else if ((state_r == ST_LOCKED) && (bit_idx_r != TAG_HI)) begin
         in_frame = 1'b1;
         cur_idx  = bit_idx_r;
      end else begin
         in_frame = 1'b0;
         cur_idx  = 8'd0;
      end
   end

   // Previous sync sample; kept tracking through reset so a sync that is
   // already high when reset releases is not mistaken for a rising edge.
   always_ff @(negedge clk) begin
      sync_prev_r <= sync;
   end

   // Frame state, bit index and framing-error pulse.
   always_ff @(negedge clk) begin
      if (rst) begin
         state_r   <= ST_HUNT;
         bit_idx_r <= 8'd0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state_r)
            ST_HUNT: begin
               if (rise_s) begin
                  state_r   <= ST_LOCKED;
                  bit_idx_r <= TAG_HI - 8'd1;
               end else begin
                  bit_idx_r <= 8'd0;
               end
            end
            ST_LOCKED: begin
               // bit_idx_r wraps from 0 to 255, so 255 means "sync due now".
               if (bit_idx_r == TAG_HI) begin
                  if (rise_s) begin
                     bit_idx_r <= TAG_HI - 8'd1;
                  end else begin
                     frame_err <= 1'b1;
                     state_r   <= ST_HUNT;
                     bit_idx_r <= 8'd0;
                  end
               end else if (rise_s) begin
                  // Early sync: drop the partial frame and realign on it.
                  frame_err <= 1'b1;
                  bit_idx_r <= TAG_HI - 8'd1;
               end else begin
                  bit_idx_r <= bit_idx_r - 8'd1;
               end
            end
            default: begin
               state_r   <= ST_HUNT;
               bit_idx_r <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ac97_sdata_in_rx.sv
// ac97_sdata_in_rx
// AC'97 SDATA_IN receiver. Captures the tag, status address/data, slot
// requests and the two PCM slots of each frame from the codec, then
// publishes them one edge after the last slot-4 bit. Outputs for slots not
// flagged valid in the tag keep their previous values.
// Ports:
//   AC97_BIT_CLOCK in  codec bit clock, falling edge active
//   SYSTEM_Rst     in  synchronous active-high reset
//   AC97_SYNCH     in  frame sync from the local transmitter
//   AC97_SDATA_IN  in  serial data from the codec, MSB first
//   codec_ready    out tag bit 15 of the last good frame
//   status_addr    out slot 1 bits 18:12 (status register address)
//   status_data    out slot 2 bits 19:4  (status register data)
//   status_valid   out one-cycle pulse when status_addr/status_data update
//   slot_req       out slot 1 bits 11:2 (codec slot requests)
//   pcm_left/right out slot 3 / slot 4 bits 19:(20-PCM_W)
//   pcm_valid      out one-cycle pulse when both PCM outputs update
//   frame_err      out one-cycle framing error pulse
// PCM_W must lie in 1..20.
module ac97_sdata_in_rx
   import ac97_sdata_in_rx_pkg::*;
#(
   parameter int PCM_W = 16
) (
   input  logic             AC97_BIT_CLOCK,
   input  logic             SYSTEM_Rst,
   input  logic             AC97_SYNCH,
   input  logic             AC97_SDATA_IN,
   output logic             codec_ready,
   output logic [6:0]       status_addr,
   output logic [15:0]      status_data,
   output logic             status_valid,
   output logic [9:0]       slot_req,
   output logic [PCM_W-1:0] pcm_left,
   output logic [PCM_W-1:0] pcm_right,
   output logic             pcm_valid,
   output logic             frame_err
);

   // Only the wanted field bits are shifted in, each over its own index window.
   localparam logic [IDX_W-1:0] TAG_FLD_HI  = tag_pos(TAG_READY);
   localparam logic [IDX_W-1:0] TAG_FLD_LO  = tag_pos(TAG_SLOT4);
   localparam logic [IDX_W-1:0] ADDR_HI     = slot_pos(SLOT1_HI, 18);
   localparam logic [IDX_W-1:0] ADDR_LO     = slot_pos(SLOT1_HI, 12);
   localparam logic [IDX_W-1:0] REQ_HI      = slot_pos(SLOT1_HI, 11);
   localparam logic [IDX_W-1:0] REQ_LO      = slot_pos(SLOT1_HI, 2);
   localparam logic [IDX_W-1:0] DATA_HI     = slot_pos(SLOT2_HI, 19);
   localparam logic [IDX_W-1:0] DATA_LO     = slot_pos(SLOT2_HI, 4);
   localparam logic [IDX_W-1:0] LEFT_HI     = slot_pos(SLOT3_HI, 19);
   localparam logic [IDX_W-1:0] LEFT_LO     = slot_pos(SLOT3_HI, 20 - PCM_W);
   localparam logic [IDX_W-1:0] RIGHT_HI    = slot_pos(SLOT4_HI, 19);
   localparam logic [IDX_W-1:0] RIGHT_LO    = slot_pos(SLOT4_HI, 20 - PCM_W);
   // tag_r holds tag bits TAG_READY..TAG_SLOT4.
   localparam int T_READY = TAG_READY - TAG_SLOT4;
   localparam int T_SLOT1 = TAG_SLOT1 - TAG_SLOT4;
   localparam int T_SLOT2 = TAG_SLOT2 - TAG_SLOT4;
   localparam int T_SLOT3 = TAG_SLOT3 - TAG_SLOT4;
   localparam int T_SLOT4 = 0;

   logic             in_frame;
   logic [IDX_W-1:0] cur_idx;
   logic [4:0]       tag_r;
   logic [6:0]       addr_r;
   logic [9:0]       req_r;
   logic [15:0]      data_r;
   logic [PCM_W-1:0] left_r;
   logic [PCM_W-1:0] right_r;
   logic             commit_r;

   ac97_frame_counter u_frame_counter (
      .clk       (AC97_BIT_CLOCK),
      .rst       (SYSTEM_Rst),
      .sync      (AC97_SYNCH),
      .in_frame  (in_frame),
      .cur_idx   (cur_idx),
      .frame_err (frame_err)
   );

   // Field capture and commit strobe for the edge after slot 4 completes.
   always_ff @(negedge AC97_BIT_CLOCK) begin
      if (SYSTEM_Rst) begin
         tag_r    <= 5'd0;
         addr_r   <= 7'd0;
         req_r    <= 10'd0;
         data_r   <= 16'd0;
         left_r   <= {PCM_W{1'b0}};
         right_r  <= {PCM_W{1'b0}};
         commit_r <= 1'b0;
      end else begin
         commit_r <= in_frame && (cur_idx == SLOT4_LO);
         if (in_frame) begin
            if (in_range(cur_idx, TAG_FLD_HI, TAG_FLD_LO)) tag_r   <= {tag_r[3:0], AC97_SDATA_IN};
            if (in_range(cur_idx, ADDR_HI, ADDR_LO))       addr_r  <= {addr_r[5:0], AC97_SDATA_IN};
            if (in_range(cur_idx, REQ_HI, REQ_LO))         req_r   <= {req_r[8:0], AC97_SDATA_IN};
            if (in_range(cur_idx, DATA_HI, DATA_LO))       data_r  <= {data_r[14:0], AC97_SDATA_IN};
            // Shift-or form keeps PCM_W = 1 legal.
            if (in_range(cur_idx, LEFT_HI, LEFT_LO))   left_r  <= (left_r << 1)  | PCM_W'(AC97_SDATA_IN);
            if (in_range(cur_idx, RIGHT_HI, RIGHT_LO)) right_r <= (right_r << 1) | PCM_W'(AC97_SDATA_IN);
         end
      end
   end

   // Output registers: publish the captured frame and pulse the valids.
   always_ff @(negedge AC97_BIT_CLOCK) begin
      if (SYSTEM_Rst) begin
         codec_ready  <= 1'b0;
         slot_req     <= 10'd0;
         status_addr  <= 7'd0;
         status_data  <= 16'd0;
         status_valid <= 1'b0;
         pcm_left     <= {PCM_W{1'b0}};
         pcm_right    <= {PCM_W{1'b0}};
         pcm_valid    <= 1'b0;
      end else begin
         status_valid <= 1'b0;
         pcm_valid    <= 1'b0;
         if (commit_r) begin
            codec_ready <= tag_r[T_READY];
            slot_req    <= req_r;
            if (tag_r[T_SLOT3] && tag_r[T_SLOT4]) begin
               pcm_left  <= left_r;
               pcm_right <= right_r;
               pcm_valid <= 1'b1;
            end
            if (tag_r[T_SLOT1] && tag_r[T_SLOT2]) begin
               status_addr  <= addr_r;
               status_data  <= data_r;
               status_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ac97_sdata_in_rx.sv
// Testbench for ac97_sdata_in_rx: two instances (PCM_W = 16 and 20) share
// one stimulus stream of directed frames. Expected pulses are queued by the
// stimulus with the clock edge they must appear on; monitors pop and compare.
module tb_ac97_sdata_in_rx;

   typedef struct packed {
      logic [31:0] edge_n;
      logic [19:0] a;
      logic [19:0] b;
   } exp_t;

   logic clk, rst, sync, sdata;
   logic cr0, sv0, pv0, fe0, cr1, sv1, pv1, fe1;
   logic [6:0]  sa0, sa1;
   logic [15:0] sd0, sd1;
   logic [9:0]  rq0, rq1;
   logic [15:0] pl0, pr0;
   logic [19:0] pl1, pr1;

   int n_cmp = 0;
   int n_fail = 0;
   int edge_n = 0;
   exp_t pcm_q0[$], pcm_q1[$], st_q0[$], st_q1[$], er_q0[$], er_q1[$];
   exp_t m0, m1;

   ac97_sdata_in_rx #(.PCM_W(16)) u_dut16 (
      .AC97_BIT_CLOCK(clk), .SYSTEM_Rst(rst), .AC97_SYNCH(sync), .AC97_SDATA_IN(sdata),
      .codec_ready(cr0), .status_addr(sa0), .status_data(sd0), .status_valid(sv0),
      .slot_req(rq0), .pcm_left(pl0), .pcm_right(pr0), .pcm_valid(pv0), .frame_err(fe0));

   ac97_sdata_in_rx #(.PCM_W(20)) u_dut20 (
      .AC97_BIT_CLOCK(clk), .SYSTEM_Rst(rst), .AC97_SYNCH(sync), .AC97_SDATA_IN(sdata),
      .codec_ready(cr1), .status_addr(sa1), .status_data(sd1), .status_valid(sv1),
      .slot_req(rq1), .pcm_left(pl1), .pcm_right(pr1), .pcm_valid(pv1), .frame_err(fe1));

   initial begin
      clk = 1'b0;
      forever #40 clk = ~clk;
   end

   always @(negedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, edge_n);
      end
   endtask

   // Monitor for the 16-bit instance.
   always @(posedge clk) begin
      if (pv0) begin
         if (pcm_q0.size() == 0) chk("pcm16_unexpected_pulse", 32'(pv0), 32'd0);
         else begin
            m0 = pcm_q0.pop_front();
            chk("pcm16_edge", 32'(edge_n), m0.edge_n);
            chk("pcm16_left", 32'(pl0), 32'(m0.a[19:4]));
            chk("pcm16_right", 32'(pr0), 32'(m0.b[19:4]));
         end
      end
      if (sv0) begin
         if (st_q0.size() == 0) chk("status16_unexpected_pulse", 32'(sv0), 32'd0);
         else begin
            m0 = st_q0.pop_front();
            chk("status16_edge", 32'(edge_n), m0.edge_n);
            chk("status16_addr", 32'(sa0), 32'(m0.a));
            chk("status16_data", 32'(sd0), 32'(m0.b));
         end
      end
      if (fe0) begin
         if (er_q0.size() == 0) chk("err16_unexpected_pulse", 32'(fe0), 32'd0);
         else begin
            m0 = er_q0.pop_front();
            chk("err16_edge", 32'(edge_n), m0.edge_n);
         end
      end
   end

   // Monitor for the 20-bit instance.
   always @(posedge clk) begin
      if (pv1) begin
         if (pcm_q1.size() == 0) chk("pcm20_unexpected_pulse", 32'(pv1), 32'd0);
         else begin
            m1 = pcm_q1.pop_front();
            chk("pcm20_edge", 32'(edge_n), m1.edge_n);
            chk("pcm20_left", 32'(pl1), 32'(m1.a));
            chk("pcm20_right", 32'(pr1), 32'(m1.b));
         end
      end
      if (sv1) begin
         if (st_q1.size() == 0) chk("status20_unexpected_pulse", 32'(sv1), 32'd0);
         else begin
            m1 = st_q1.pop_front();
            chk("status20_edge", 32'(edge_n), m1.edge_n);
            chk("status20_addr", 32'(sa1), 32'(m1.a));
            chk("status20_data", 32'(sd1), 32'(m1.b));
         end
      end
      if (fe1) begin
         if (er_q1.size() == 0) chk("err20_unexpected_pulse", 32'(fe1), 32'd0);
         else begin
            m1 = er_q1.pop_front();
            chk("err20_edge", 32'(edge_n), m1.edge_n);
         end
      end
   end

   // Drive one bit just after the rising edge; the DUT samples it on the next falling edge.
   task automatic drive_bit(input logic s, input logic d, input logic r);
      @(posedge clk);
      sync  = s;
      sdata = d;
      rst   = r;
   endtask

   task automatic push_err(input int e);
      exp_t x;
      x.edge_n = 32'(e);
      x.a = 20'd0;
      x.b = 20'd0;
      er_q0.push_back(x);
      er_q1.push_back(x);
   endtask

   // Full frame from bit 255 down to abort_at+1 (abort_at = -1 sends all 256 bits).
   task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                             input logic [19:0] s3, input logic [19:0] s4,
                             input int abort_at, input bit err_first);
      logic d;
      exp_t x;
      for (int idx = 255; idx > abort_at; idx--) begin
         if (idx >= 240)      d = tag[4'(idx - 240)];
         else if (idx >= 220) d = s1[5'(idx - 220)];
         else if (idx >= 200) d = s2[5'(idx - 200)];
         else if (idx >= 180) d = s3[5'(idx - 180)];
         else if (idx >= 160) d = s4[5'(idx - 160)];
         else                 d = ((idx % 3) == 0);
         drive_bit(idx >= 240, d, 1'b0);
         if (idx == 255 && err_first) push_err(edge_n + 1);
         if (idx == 160) begin
            // Bit 160 is sampled at edge_n+1; the commit shows after edge_n+2.
            x.edge_n = 32'(edge_n + 2);
            if (tag[12] && tag[11]) begin
               x.a = s3;
               x.b = s4;
               pcm_q0.push_back(x);
               pcm_q1.push_back(x);
            end
            if (tag[14] && tag[13]) begin
               x.a = {13'd0, s1[18:12]};
               x.b = {4'd0, s2[19:4]};
               st_q0.push_back(x);
               st_q1.push_back(x);
            end
         end
      end
   endtask

   task automatic send_idle(input int n, input bit err_first);
      for (int i = 0; i < n; i++) begin
         drive_bit(1'b0, 1'b0, 1'b0);
         if (i == 0 && err_first) push_err(edge_n + 1);
      end
   endtask

   task automatic check_outs(input string nm, input logic cr, input logic [9:0] req,
                             input logic [6:0] addr, input logic [15:0] data,
                             input logic [19:0] l, input logic [19:0] r);
      chk({nm, "_codec_ready16"}, 32'(cr0), 32'(cr));
      chk({nm, "_slot_req16"},    32'(rq0), 32'(req));
      chk({nm, "_status_addr16"}, 32'(sa0), 32'(addr));
      chk({nm, "_status_data16"}, 32'(sd0), 32'(data));
      chk({nm, "_pcm_left16"},    32'(pl0), 32'(l[19:4]));
      chk({nm, "_pcm_right16"},   32'(pr0), 32'(r[19:4]));
      chk({nm, "_codec_ready20"}, 32'(cr1), 32'(cr));
      chk({nm, "_slot_req20"},    32'(rq1), 32'(req));
      chk({nm, "_status_addr20"}, 32'(sa1), 32'(addr));
      chk({nm, "_status_data20"}, 32'(sd1), 32'(data));
      chk({nm, "_pcm_left20"},    32'(pl1), 32'(l));
      chk({nm, "_pcm_right20"},   32'(pr1), 32'(r));
   endtask

   initial begin
      rst = 1'b1;
      sync = 1'b0;
      sdata = 1'b0;
      repeat (3) drive_bit(1'b0, 1'b0, 1'b1);
      drive_bit(1'b0, 1'b0, 1'b0);
      check_outs("reset", 1'b0, 10'h000, 7'h00, 16'h0000, 20'h00000, 20'h00000);
      send_idle(3, 1'b0);

      // All slots valid.
      send_frame(16'hF800, 20'h26554, 20'h000F0, 20'h12345, 20'hABCDE, -1, 1'b0);
      check_outs("frame1", 1'b1, 10'h155, 7'h26, 16'h000F, 20'h12345, 20'hABCDE);

      // Slot 1 invalid: PCM updates, status holds.
      send_frame(16'h9800, 20'h7F000, 20'hFFFF0, 20'h80001, 20'h7FFFF, -1, 1'b0);
      check_outs("frame2", 1'b1, 10'h000, 7'h26, 16'h000F, 20'h80001, 20'h7FFFF);

      // No slot valid, then an early sync at bit index 100.
      send_frame(16'h8000, 20'h00008, 20'h00000, 20'h11111, 20'h22222, 100, 1'b0);
      check_outs("frame3", 1'b1, 10'h002, 7'h26, 16'h000F, 20'h80001, 20'h7FFFF);
      send_frame(16'hF800, 20'h11FFC, 20'hBEEF0, 20'hFFFF0, 20'h00010, -1, 1'b1);
      check_outs("frame4", 1'b1, 10'h3FF, 7'h11, 16'hBEEF, 20'hFFFF0, 20'h00010);

      // Sync withheld after bit 0, then relock; only status slots valid.
      send_idle(4, 1'b1);
      send_frame(16'hE000, 20'h05000, 20'h12340, 20'h55555, 20'h55555, -1, 1'b0);
      check_outs("frame5", 1'b1, 10'h000, 7'h05, 16'h1234, 20'hFFFF0, 20'h00010);

      // Codec not ready, PCM valid.
      send_frame(16'h1800, 20'h7FFFC, 20'h00000, 20'hFEDCB, 20'h01234, -1, 1'b0);
      check_outs("frame6", 1'b0, 10'h3FF, 7'h05, 16'h1234, 20'hFEDCB, 20'h01234);

      // Reset at bit 200 for three edges aborts the frame.
      send_frame(16'hF800, 20'h26554, 20'h000F0, 20'h12345, 20'hABCDE, 200, 1'b0);
      repeat (3) drive_bit(1'b0, 1'b0, 1'b1);
      drive_bit(1'b0, 1'b0, 1'b0);
      check_outs("midreset", 1'b0, 10'h000, 7'h00, 16'h0000, 20'h00000, 20'h00000);
      send_idle(2, 1'b0);
      send_frame(16'hF800, 20'h26554, 20'h000F0, 20'h12345, 20'hABCDE, -1, 1'b0);
      check_outs("frame8", 1'b1, 10'h155, 7'h26, 16'h000F, 20'h12345, 20'hABCDE);

      // Missing sync after the last frame.
      send_idle(2, 1'b1);
      @(posedge clk);
      #1;
      chk("pcm16_pending", 32'(pcm_q0.size()), 32'd0);
      chk("pcm20_pending", 32'(pcm_q1.size()), 32'd0);
      chk("status16_pending", 32'(st_q0.size()), 32'd0);
      chk("status20_pending", 32'(st_q1.size()), 32'd0);
      chk("err16_pending", 32'(er_q0.size()), 32'd0);
      chk("err20_pending", 32'(er_q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
